// File: rtl/seg7_bus_reader.sv
// seg7_bus_reader
// Receiving end of a time-multiplexed, active-low seven-segment bus.
// Each digit pattern must hold steady for STABLE clocks before it is decoded
// into its slot. Once every slot has been captured, the assembled value and
// blank mask are offered on a valid/ready interface.
module seg7_bus_reader #(
  parameter int NDIGITS = 2,
  parameter int STABLE  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:6]             seg,
  input  logic [NDIGITS-1:0]     dig_sel,
  output logic [4*NDIGITS-1:0]   value,
  output logic [NDIGITS-1:0]     blank,
  output logic                   valid,
  input  logic                   ready,
  output logic                   err
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_OFFER   = 1'b1
  } state_t;

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  // Decoded pattern: {legal, blank, nibble}. Illegal patterns return all zeros.
  function automatic logic [5:0] decode_seg(input logic [0:6] pat);
    logic [5:0] r;
    case (pat)
      7'b0000001: r = {1'b1, 1'b0, 4'h0};
      7'b1001111: r = {1'b1, 1'b0, 4'h1};
      7'b0010010: r = {1'b1, 1'b0, 4'h2};
      7'b0000110: r = {1'b1, 1'b0, 4'h3};
      7'b1001100: r = {1'b1, 1'b0, 4'h4};
      7'b0100100: r = {1'b1, 1'b0, 4'h5};
      7'b0100000: r = {1'b1, 1'b0, 4'h6};
      7'b0001111: r = {1'b1, 1'b0, 4'h7};
      7'b0000000: r = {1'b1, 1'b0, 4'h8};
      7'b0000100: r = {1'b1, 1'b0, 4'h9};
      7'b0001000: r = {1'b1, 1'b0, 4'hA};
      7'b1100000: r = {1'b1, 1'b0, 4'hB};
      7'b0110001: r = {1'b1, 1'b0, 4'hC};
      7'b1000010: r = {1'b1, 1'b0, 4'hD};
      7'b0110000: r = {1'b1, 1'b0, 4'hE};
      7'b0111000: r = {1'b1, 1'b0, 4'hF};
      7'b1111111: r = {1'b1, 1'b1, 4'h0};
      default:    r = 6'b000000;
    endcase
    return r;
  endfunction

  // True when exactly one digit-select line is active.
  function automatic logic is_onehot(input logic [NDIGITS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NDIGITS; i++) begin
      n = n + int'(v[i]);
    end
    return (n == 1);
  endfunction

  // Registered state
  state_t                 state_q, state_d;
  logic [0:6]             s_seg_q, s_seg_d;
  logic [NDIGITS-1:0]     s_sel_q, s_sel_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [4*NDIGITS-1:0]   slot_val_q, slot_val_d;
  logic [NDIGITS-1:0]     slot_blank_q, slot_blank_d;
  logic [NDIGITS-1:0]     captured_q, captured_d;
  logic [4*NDIGITS-1:0]   value_q, value_d;
  logic [NDIGITS-1:0]     blank_q, blank_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  // Combinational helpers
  logic                   onehot_s;
  logic                   changed_s;
  logic                   capture_s;
  logic [5:0]             dec_s;

  // Input sampling and the stability counter that qualifies a digit.
  always_comb begin
    s_seg_d   = seg;
    s_sel_d   = dig_sel;
    onehot_s  = is_onehot(dig_sel);
    changed_s = ({seg, dig_sel} != {s_seg_q, s_sel_q});
    cnt_d     = cnt_q;
    if (state_q == ST_OFFER) begin
      // Paused while offering; any pattern must re-qualify from zero afterwards.
      cnt_d = 8'd0;
    end else if (!onehot_s) begin
      cnt_d = 8'd0;
    end else if (changed_s) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= STABLE_C) begin
      cnt_d = STABLE_C;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    // Capture only on the edge where the count first reaches STABLE, so a
    // saturated run never captures twice.
    capture_s = (state_q == ST_COLLECT) && (cnt_d == STABLE_C) && (cnt_q != STABLE_C);
  end

  // Decode the qualified pattern into the selected slot, or flag it as illegal.
  always_comb begin
    dec_s        = decode_seg(seg);
    slot_val_d   = slot_val_q;
    slot_blank_d = slot_blank_q;
    captured_d   = captured_q;
    err_d        = 1'b0;
    if (capture_s) begin
      if (dec_s[5]) begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (dig_sel[i]) begin
            slot_val_d[4*i +: 4] = dec_s[3:0];
            slot_blank_d[i]      = dec_s[4];
            captured_d[i]        = 1'b1;
          end else begin
            slot_val_d[4*i +: 4] = slot_val_q[4*i +: 4];
            slot_blank_d[i]      = slot_blank_q[i];
            captured_d[i]        = captured_q[i];
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = 1'b0;
    end

    // The handshake releases all captured slots for the next collection.
    if ((state_q == ST_OFFER) && valid_q && ready) begin
      captured_d = '0;
    end else begin
      captured_d = captured_d;
    end
  end

  // Next-state logic for the collect/offer sequencer and its output registers.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    value_d = value_q;
    blank_d = blank_q;
    case (state_q)
      ST_COLLECT: begin
        if (&captured_q) begin
          state_d = ST_OFFER;
          valid_d = 1'b1;
          value_d = slot_val_q;
          blank_d = slot_blank_q;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_OFFER: begin
        if (valid_q && ready) begin
          state_d = ST_COLLECT;
          valid_d = 1'b0;
        end else begin
          state_d = ST_OFFER;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        valid_d = 1'b0;
      end
    endcase
  end

  // All state registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      s_seg_q      <= 7'b1111111;
      s_sel_q      <= '0;
      cnt_q        <= 8'd0;
      slot_val_q   <= '0;
      slot_blank_q <= '0;
      captured_q   <= '0;
      value_q      <= '0;
      blank_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_seg_q      <= s_seg_d;
      s_sel_q      <= s_sel_d;
      cnt_q        <= cnt_d;
      slot_val_q   <= slot_val_d;
      slot_blank_q <= slot_blank_d;
      captured_q   <= captured_d;
      value_q      <= value_d;
      blank_q      <= blank_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign value = value_q;
  assign blank = blank_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seg7_bus_reader.sv
// Directed bench for seg7_bus_reader with NDIGITS=2, STABLE=4.
module tb_seg7_bus_reader;

  localparam logic [0:6] P_0   = 7'b0000001;
  localparam logic [0:6] P_1   = 7'b1001111;
  localparam logic [0:6] P_2   = 7'b0010010;
  localparam logic [0:6] P_3   = 7'b0000110;
  localparam logic [0:6] P_4   = 7'b1001100;
  localparam logic [0:6] P_5   = 7'b0100100;
  localparam logic [0:6] P_6   = 7'b0100000;
  localparam logic [0:6] P_7   = 7'b0001111;
  localparam logic [0:6] P_9   = 7'b0000100;
  localparam logic [0:6] P_A   = 7'b0001000;
  localparam logic [0:6] P_B   = 7'b1100000;
  localparam logic [0:6] P_BL  = 7'b1111111;
  localparam logic [0:6] P_ILL = 7'b1010101;

  logic       clk;
  logic       rst;
  logic [0:6] seg;
  logic [1:0] dig_sel;
  logic [7:0] value;
  logic [1:0] blank;
  logic       valid;
  logic       ready;
  logic       err;

  int checks;
  int errors;
  int err_total;

  seg7_bus_reader #(.NDIGITS(2), .STABLE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .dig_sel (dig_sel),
    .value   (value),
    .blank   (blank),
    .valid   (valid),
    .ready   (ready),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (err === 1'b1) err_total++;
    end
  endtask

  task automatic drive_hold(input logic [1:0] sel, input logic [0:6] pat, input int n);
    dig_sel = sel;
    seg     = pat;
    step(n);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    err_total = 0;
    rst     = 1'b1;
    seg     = P_BL;
    dig_sel = 2'b00;
    ready   = 1'b0;
    #12;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_value", 32'(value), 32'h00);
    check_eq("rst_blank", 32'(blank), 32'd0);
    check_eq("rst_err",   32'(err),   32'd0);
    rst = 1'b0;
    step(1);

    // Basic decode: "3" on digit 0, "1" on digit 1
    drive_hold(2'b01, P_3, 4);
    drive_hold(2'b10, P_1, 4);
    check_eq("basic_pre_valid", 32'(valid), 32'd0);
    step(1);
    check_eq("basic_valid", 32'(valid), 32'd1);
    check_eq("basic_value", 32'(value), 32'h13);
    check_eq("basic_blank", 32'(blank), 32'd0);
    step(3);
    check_eq("basic_hold_valid", 32'(valid), 32'd1);
    check_eq("basic_hold_value", 32'(value), 32'h13);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check_eq("basic_hs_valid", 32'(valid), 32'd0);

    // Glitch rejection and blank digit
    drive_hold(2'b01, P_A, 3);
    drive_hold(2'b01, P_B, 4);
    drive_hold(2'b10, P_BL, 4);
    check_eq("glitch_pre_valid", 32'(valid), 32'd0);
    step(1);
    check_eq("glitch_valid", 32'(valid), 32'd1);
    check_eq("glitch_value", 32'(value), 32'h0b);
    check_eq("glitch_blank", 32'(blank), 32'b10);
    check_eq("glitch_no_err", 32'(err_total), 32'd0);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check_eq("glitch_hs_valid", 32'(valid), 32'd0);

    // Illegal pattern on digit 0 while digit 1 already holds "9"
    drive_hold(2'b10, P_9, 4);
    drive_hold(2'b01, P_ILL, 3);
    check_eq("ill_err_before", 32'(err), 32'd0);
    step(1);
    check_eq("ill_err_pulse", 32'(err), 32'd1);
    step(1);
    check_eq("ill_err_after", 32'(err), 32'd0);
    step(3);
    check_eq("ill_no_valid", 32'(valid), 32'd0);
    check_eq("ill_err_count", 32'(err_total), 32'd1);
    drive_hold(2'b01, P_7, 4);
    check_eq("ill_fill_pre_valid", 32'(valid), 32'd0);
    step(1);
    check_eq("ill_fill_valid", 32'(valid), 32'd1);
    check_eq("ill_fill_value", 32'(value), 32'h97);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check_eq("ill_fill_hs", 32'(valid), 32'd0);

    // Overwrite: "7" then "5" on digit 0, then "2" on digit 1
    drive_hold(2'b01, P_7, 4);
    drive_hold(2'b01, P_5, 4);
    drive_hold(2'b10, P_2, 4);
    check_eq("ovw_pre_valid", 32'(valid), 32'd0);
    step(1);
    check_eq("ovw_valid", 32'(valid), 32'd1);
    check_eq("ovw_value", 32'(value), 32'h25);

    // Handshake collision: "2" stays on the bus across the handshake
    ready = 1'b1;
    step(1);
    check_eq("coll_hs_valid", 32'(valid), 32'd0);
    drive_hold(2'b10, P_2, 3);
    drive_hold(2'b01, P_0, 4);
    step(2);
    check_eq("coll_requalify", 32'(valid), 32'd0);
    drive_hold(2'b10, P_2, 4);
    check_eq("coll_pre_valid", 32'(valid), 32'd0);
    step(1);
    check_eq("coll_valid", 32'(valid), 32'd1);
    check_eq("coll_value", 32'(value), 32'h20);
    step(1);
    check_eq("coll_hs2_valid", 32'(valid), 32'd0);
    ready = 1'b0;

    // Asynchronous reset while offering
    drive_hold(2'b01, P_4, 4);
    drive_hold(2'b10, P_6, 4);
    step(1);
    check_eq("arst_pre_valid", 32'(valid), 32'd1);
    check_eq("arst_pre_value", 32'(value), 32'h64);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_value", 32'(value), 32'h00);
    check_eq("arst_blank", 32'(blank), 32'd0);
    check_eq("arst_err",   32'(err),   32'd0);
    #1;
    rst = 1'b0;
    step(1);

    // Reset mid-collect discards the partial capture
    drive_hold(2'b01, P_4, 4);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive_hold(2'b10, P_6, 4);
    step(3);
    check_eq("mid_rst_no_valid", 32'(valid), 32'd0);
    drive_hold(2'b01, P_4, 4);
    step(1);
    check_eq("mid_rst_valid", 32'(valid), 32'd1);
    check_eq("mid_rst_value", 32'(value), 32'h64);
    check_eq("final_err_count", 32'(err_total), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
